crc8_frame_tx: RTL and testbench

- Transmit-side framer that drives the CRC-8 LFSR stage in the serial link.
- Accepts a byte stream on a valid/ready handshake and serializes it MSB-first, one bit per clock.
- Runs the same CRC-8 LFSR internally (poly x^8+x^5+x^4+1, 0x31, init 0x00, no reflection, no final XOR).
- After the byte flagged last, appends the 8 CRC bits MSB-first. A downstream CRC checker fed the whole bitstream ends at 0x00.

---
 rtl/crc8_frame_tx.sv | 195 +++++++++++++++++++
 tb/tb_crc8_frame_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_tx.sv
// Serial CRC-8 (poly 0x31) framer: serializes payload bytes MSB-first and appends the frame CRC.
// Optional abort port pair is enabled by defining CRC8_FRAME_TX_ABORT_EN.
module crc8_frame_tx #(
  parameter logic IDLE_BITVAL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
`ifdef CRC8_FRAME_TX_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       in_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       bit_first,
  output logic       bit_last,
  output logic [7:0] crc_out,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_TRAIL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic [7:0] crc_q, crc_d;
  logic       bit_out_q, bit_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic       bit_first_q, bit_first_d;
  logic       bit_last_q, bit_last_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       aborted_q, aborted_d;
  logic       abort_hit_s;
  logic       ready_s;
  logic       accept_s;
  logic [7:0] crc_next_s;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic inv;
    inv = b ^ c[7];
    return {c[6], c[5], c[4] ^ inv, c[3] ^ inv, c[2], c[1], c[0], inv};
  endfunction

`ifdef CRC8_FRAME_TX_ABORT_EN
  assign abort_hit_s = abort && ((state_q == S_SHIFT) || (state_q == S_GAP) || (state_q == S_TRAIL));
  assign aborted     = aborted_q;
`else
  assign abort_hit_s = 1'b0;
`endif

  // A byte can be taken in IDLE, GAP, or on the 8th bit of a non-final byte.
  assign ready_s = !abort_hit_s &&
                   ((state_q == S_IDLE) || (state_q == S_GAP) ||
                    ((state_q == S_SHIFT) && (cnt_q == 3'd0) && !last_q));
  assign accept_s   = in_valid && ready_s;
  assign crc_next_s = crc_step(crc_q, sh_q[7]);

  // State register and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sh_q         <= 8'h00;
      cnt_q        <= 3'd0;
      last_q       <= 1'b0;
      crc_q        <= 8'h00;
      bit_out_q    <= IDLE_BITVAL;
      bit_valid_q  <= 1'b0;
      bit_first_q  <= 1'b0;
      bit_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      crc_q        <= crc_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_first_q  <= bit_first_d;
      bit_last_q   <= bit_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    crc_d   = crc_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          crc_d   = 8'h00;
          sh_d    = in_data;
          cnt_d   = 3'd7;
          last_d  = in_last;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        crc_d = crc_next_s;
        sh_d  = {sh_q[6:0], 1'b0};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          if (last_q) begin
            // Trailer shifts out the CRC including this final payload bit.
            sh_d    = crc_next_s;
            cnt_d   = 3'd7;
            state_d = S_TRAIL;
          end else if (accept_s) begin
            sh_d   = in_data;
            cnt_d  = 3'd7;
            last_d = in_last;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_GAP: begin
        if (accept_s) begin
          sh_d    = in_data;
          cnt_d   = 3'd7;
          last_d  = in_last;
          state_d = S_SHIFT;
        end else begin
          state_d = S_GAP;
        end
      end
      S_TRAIL: begin
        sh_d  = {sh_q[6:0], 1'b0};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_hit_s) begin
      state_d = S_IDLE;
      crc_d   = 8'h00;
    end else begin
      crc_d = crc_d;
    end
  end

  // Output decode from the upcoming state so every strobe leaves a flop.
  always_comb begin
    bit_valid_d  = (state_d == S_SHIFT) || (state_d == S_TRAIL);
    bit_out_d    = bit_valid_d ? sh_d[7] : IDLE_BITVAL;
    bit_first_d  = (state_q == S_IDLE) && accept_s;
    bit_last_d   = (state_d == S_TRAIL) && (cnt_d == 3'd0);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    aborted_d    = abort_hit_s;
  end

  assign in_ready   = ready_s;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign bit_first  = bit_first_q;
  assign bit_last   = bit_last_q;
  assign crc_out    = crc_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Randomized bench for crc8_frame_tx against a byte-level CRC model and a long-division residue check.
module tb_crc8_frame_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_first;
  logic       bit_last;
  logic [7:0] crc_out;
  logic       busy;
  logic       frame_done;
`ifdef CRC8_FRAME_TX_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] frame_bytes [0:7];
  int         frame_gap   [0:7];

  crc8_frame_tx #(.IDLE_BITVAL(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
`ifdef CRC8_FRAME_TX_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .in_ready   (in_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_first  (bit_first),
    .bit_last   (bit_last),
    .crc_out    (crc_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-wise CRC-8: xor the byte in, then eight polynomial reduction steps.
  function automatic logic [7:0] ref_crc(input int len);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < len; i++) begin
      c = c ^ frame_bytes[i];
      for (int k = 0; k < 8; k++) begin
        if (c[7]) c = {c[6:0], 1'b0} ^ 8'h31;
        else      c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Polynomial long division of the whole bitstream by x^8+x^5+x^4+1.
  function automatic logic [7:0] residue(input logic [63:0] bits, input int n);
    logic [8:0] r;
    r = 9'h000;
    for (int i = n - 1; i >= 0; i--) begin
      r = {r[7:0], bits[i]};
      if (r[8]) r = r ^ 9'h131;
    end
    return r[7:0];
  endfunction

  task automatic run_frame(input int len, input string tag);
    logic [63:0] exp_bits, got_bits;
    logic [7:0]  exp_crc;
    int exp_n, nbits, first_pos, last_pos, bubbles, exp_bubbles, idx, gap_left, cyc;
    bit done_seen, done_after_last, prev_last;
    exp_crc  = ref_crc(len);
    exp_bits = 64'h0;
    for (int i = 0; i < len; i++) exp_bits = {exp_bits[55:0], frame_bytes[i]};
    exp_bits = {exp_bits[55:0], exp_crc};
    exp_n    = 8 * len + 8;
    exp_bubbles = 0;
    for (int i = 1; i < len; i++) exp_bubbles += frame_gap[i];
    got_bits = 64'h0;
    nbits = 0; first_pos = -1; last_pos = -1; bubbles = 0;
    idx = 0; gap_left = 0; cyc = 0;
    done_seen = 1'b0; done_after_last = 1'b0; prev_last = 1'b0;
    while (!done_seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (bit_valid) begin
        got_bits = {got_bits[62:0], bit_out};
        if (bit_first) first_pos = nbits;
        if (bit_last) last_pos = nbits;
        nbits++;
      end else if (nbits > 0 && last_pos < 0) begin
        bubbles++;
      end
      if (frame_done) begin
        done_seen = 1'b1;
        done_after_last = prev_last;
      end
      prev_last = bit_valid && bit_last;
      if (idx < len) begin
        if (gap_left > 0) begin
          in_valid = 1'b0;
          if (in_ready) gap_left--;
        end else begin
          in_valid = 1'b1;
          in_data  = frame_bytes[idx];
          in_last  = (idx == len - 1);
          if (in_ready) begin
            idx++;
            if (idx < len) gap_left = frame_gap[idx];
          end
        end
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    check({tag, " frame_done seen"}, 64'(done_seen), 64'd1);
    check({tag, " bit count"}, 64'(nbits), 64'(exp_n));
    check({tag, " bitstream"}, got_bits, exp_bits);
    check({tag, " bit_first pos"}, 64'(first_pos), 64'd0);
    check({tag, " bit_last pos"}, 64'(last_pos), 64'(exp_n - 1));
    check({tag, " done after last"}, 64'(done_after_last), 64'd1);
    check({tag, " gap cycles"}, 64'(bubbles), 64'(exp_bubbles));
    check({tag, " crc_out"}, 64'(crc_out), 64'(exp_crc));
    check({tag, " residue"}, 64'(residue(got_bits, nbits)), 64'd0);
    @(negedge clock);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
    check({tag, " idle ready"}, 64'(in_ready), 64'd1);
    check({tag, " done one cycle"}, 64'(frame_done), 64'd0);
    check({tag, " crc held"}, 64'(crc_out), 64'(exp_crc));
  endtask

  initial begin
    int nb, cyc, done_cnt;
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
`ifdef CRC8_FRAME_TX_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset bit_valid", 64'(bit_valid), 64'd0);
    check("reset bit_out", 64'(bit_out), 64'd0);
    check("reset crc_out", 64'(crc_out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset strobes", 64'({bit_first, bit_last, frame_done}), 64'd0);

    // Directed frames from known CRC values.
    frame_bytes[0] = 8'h01; frame_gap[0] = 0;
    run_frame(1, "single 01");
    check("single 01 crc const", 64'(crc_out), 64'h31);
    frame_bytes[1] = 8'h00; frame_gap[1] = 0;
    run_frame(2, "b2b 01 00");
    check("b2b crc const", 64'(crc_out), 64'hF4);
    frame_gap[1] = 5;
    run_frame(2, "gap 01 00");
    check("gap crc const", 64'(crc_out), 64'hF4);
    frame_bytes[0] = 8'h00;
    run_frame(1, "single 00");
    check("single 00 crc const", 64'(crc_out), 64'h00);

    // Reset on the 4th trailer bit of a single-byte frame.
    frame_bytes[0] = 8'h01;
    nb = 0; cyc = 0;
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
    while (nb < 12 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (in_ready && busy) in_valid = 1'b0;
      if (bit_valid) nb++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("reset point reached", 64'(nb), 64'd12);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset bit_valid", 64'(bit_valid), 64'd0);
    check("midreset crc_out", 64'(crc_out), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (frame_done || bit_valid) done_cnt++;
    end
    check("midreset no trailer", 64'(done_cnt), 64'd0);
    run_frame(1, "post reset 01");
    check("post reset crc const", 64'(crc_out), 64'h31);

`ifdef CRC8_FRAME_TX_ABORT_EN
    nb = 0; cyc = 0;
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
    while (nb < 3 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bit_valid) nb++;
    end
    abort = 1'b1;
    @(negedge clock);
    check("abort pulse", 64'(aborted), 64'd1);
    check("abort bit_valid", 64'(bit_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort ready", 64'(in_ready), 64'd1);
    check("abort crc", 64'(crc_out), 64'd0);
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clock);
    check("abort one cycle", 64'(aborted), 64'd0);
    run_frame(1, "post abort 01");
    check("post abort crc const", 64'(crc_out), 64'h31);
`endif

    // Random multi-byte frames with random inter-byte gaps.
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        frame_bytes[i] = 8'($urandom);
        frame_gap[i]   = (i == 0) ? 0 : $urandom_range(0, 3);
      end
      run_frame(len, $sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
